alu_dispatch: RTL and testbench
===============================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 SHALL have ports clk (in, 1, sole clock) and rst_n (in, 1, reset); one clock, reset asynchronous active-low.
REQ-002 SHALL have the instruction handshake: instr_valid in 1; instr_ready out 1; opcode in 8; cb_prefix in 1 (1 = opcode followed a CB prefix).
REQ-003 SHALL have two register read ports: rf_rd_addr_a out 3 with rf_rd_data_a in 8, and rf_rd_addr_b out 3 with rf_rd_data_b in 8; read data is combinational and same-cycle.
REQ-004 SHALL have the register write port: rf_wr_en out 1; rf_wr_addr out 3; rf_wr_data out 8.
REQ-005 SHALL have flag ports: flags_q in 8 (current F); flags_wr_en out 1; flags_wr_data out 8.
REQ-006 SHALL have (HL) memory ports: mem_rd_req out 1; mem_wr_req out 1; mem_wdata out 8; mem_rdata in 8; mem_ack in 1.
REQ-007 SHALL have ALU-side outputs alu_op (3), alu_ext (1), alu_misc (1), alu_src_addr (3), alu_dest_addr (3), alu_src_data (8), alu_dest_data (8), alu_flags_in (8), and alu_begin (1).
REQ-008 SHALL have ALU-side inputs alu_res (8) and alu_flags_res (8), plus the output done (1, one-cycle completion pulse).

Function
REQ-009 SHALL use register index encoding 0 B, 1 C, 2 D, 3 E, 4 H, 5 L, 6 (HL) memory, 7 A.
REQ-010 SHALL decode cb_prefix=0 with opcode[7:6]=10 as base ALU: op=[5:3], ext=0, misc=0, src=[2:0], dest=7; src_data=operand, dest_data=A.
REQ-011 SHALL decode cb_prefix=0 with opcode in {27h,2Fh,37h,3Fh} as misc: op={0,[4:3]}, ext=0, misc=1, src=dest=7, src_data=dest_data=A.
REQ-012 SHALL decode cb_prefix=1 with [7:6]=00 as ext: op=[5:3], misc=0, src=dest=[2:0], src_data=dest_data=operand.
REQ-013 SHALL decode cb_prefix=1 with [7:6]!=00 as bit ops: op={0,[7:6]}, ext=1, misc=1, src=[5:3] (bit number), dest=[2:0], src_data=dest_data=operand.
REQ-014 SHALL treat any other opcode as illegal: accept it, write nothing, and pulse done one cycle after acceptance.
REQ-015 SHALL run states IDLE, MEMRD, EXEC, WAIT, WB, MEMWR; instr_ready=1 only in IDLE.
REQ-016 SHALL, in IDLE with instr_valid=1, latch opcode/cb_prefix, then go to MEMRD if the operand index is 6, else to EXEC.
REQ-017 SHALL, in MEMRD, hold mem_rd_req=1 until a cycle with mem_ack=1, capture mem_rdata as the operand, then go to EXEC.
REQ-018 SHALL, in EXEC, drive alu_begin=1 for exactly one cycle with all alu_* outputs registered and stable from that cycle through WB; alu_flags_in=flags_q sampled on entry to EXEC; EXEC always proceeds to WAIT.
REQ-019 SHALL, in WAIT, hold alu_begin=0 for one cycle, then go to WB.
REQ-020 SHALL, in WB, capture alu_res/alu_flags_res and drive flags_wr_en=1 with flags_wr_data=alu_flags_res, except for RES/SET (no flag write).
REQ-021 SHALL, in WB, write alu_res to register dest (rf_wr_en=1) for the same cycle unless the op is CP (base op 7) or BIT, or dest is 6.
REQ-022 SHALL, in WB, go to MEMWR if dest is 6 and the op writes, else pulse done and return to IDLE.
REQ-023 SHALL, in MEMWR, hold mem_wr_req=1 with mem_wdata=result until mem_ack=1, then pulse done and return to IDLE.
REQ-024 SHALL give register-operand latency of 4 cycles from the acceptance edge to done (EXEC, WAIT, WB plus the done edge); (HL) adds one cycle per wait state plus one.
REQ-025 SHALL ignore mem_ack outside MEMRD/MEMWR, and SHALL never assert mem_rd_req and mem_wr_req together.

Reset
REQ-026 SHALL, on rst_n=0 at any time, immediately enter IDLE and clear every output to 0 except instr_ready, which is 1 (in IDLE).
REQ-027 SHALL, when reset occurs mid-operation, abandon the instruction without any further rf, flags or memory write; the first cycle after release accepts a new instruction.

Verification
REQ-028 SHALL pass: A=3Ch, B=0Fh, opcode 80h (ADD A,B) -> one alu_begin pulse with src_data 0Fh, dest_data 3Ch; rf write of 4Bh to A in WB; done 4 cycles after accept.
REQ-029 SHALL pass: opcode B8h (CP B) -> flags_wr_en=1 and rf_wr_en stays 0 throughout.
REQ-030 SHALL pass: CB 46h (BIT 0,(HL)), mem_ack delayed 3 cycles -> mem_rd_req held 4 cycles; flags written; no rf or memory write.
REQ-031 SHALL pass: CB C6h (SET 0,(HL)), mem_rdata 80h, alu_res 81h -> MEMWR with mem_wdata 81h; flags_wr_en stays 0.
REQ-032 SHALL pass: rst_n dropped during WAIT -> no rf_wr_en, flags_wr_en, mem_wr_req or done; instr_ready=1 during reset.
REQ-033 SHALL pass: opcode 00h with cb_prefix=0 -> done pulses one cycle after accept, with no alu_begin and no writes.

Source files
------------

// File: rtl/alu_dispatch.sv
// ALU instruction dispatcher: decodes base/CB-prefixed ALU opcodes, gathers operands from the
// register file or (HL), hands them to the ALU, then writes back the result and flags.
module alu_dispatch (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic [7:0] opcode,
  input  logic       cb_prefix,
  output logic [2:0] rf_rd_addr_a,
  input  logic [7:0] rf_rd_data_a,
  output logic [2:0] rf_rd_addr_b,
  input  logic [7:0] rf_rd_data_b,
  output logic       rf_wr_en,
  output logic [2:0] rf_wr_addr,
  output logic [7:0] rf_wr_data,
  input  logic [7:0] flags_q,
  output logic       flags_wr_en,
  output logic [7:0] flags_wr_data,
  output logic       mem_rd_req,
  output logic       mem_wr_req,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  input  logic       mem_ack,
  output logic [2:0] alu_op,
  output logic       alu_ext,
  output logic       alu_misc,
  output logic [2:0] alu_src_addr,
  output logic [2:0] alu_dest_addr,
  output logic [7:0] alu_src_data,
  output logic [7:0] alu_dest_data,
  output logic [7:0] alu_flags_in,
  output logic       alu_begin,
  input  logic [7:0] alu_res,
  input  logic [7:0] alu_flags_res,
  output logic       done
);

  localparam logic [2:0] IdxHl = 3'd6;
  localparam logic [2:0] IdxA  = 3'd7;

  typedef enum logic [2:0] {StIdle, StMemRd, StExec, StWait, StWb, StMemWr} state_e;
  state_e state_q, state_d;

  logic [7:0] op_q, res_q;
  logic       cb_q, done_q, done_d, load_alu;
  logic [7:0] cur_op;
  logic       cur_cb;
  logic       dec_legal, dec_ext, dec_misc, dec_use_a;
  logic [2:0] dec_op, dec_src, dec_dest, dec_opnd;
  logic [7:0] opnd_data;
  logic       rd_active, is_bitop, no_flags, writes_res;

  logic [2:0] alu_op_q, alu_src_addr_q, alu_dest_addr_q;
  logic       alu_ext_q, alu_misc_q;
  logic [7:0] alu_src_data_q, alu_dest_data_q, alu_flags_in_q;

  // Decode the live opcode while idle, the latched one while waiting on (HL).
  always_comb begin
    cur_op    = (state_q == StIdle) ? opcode : op_q;
    cur_cb    = (state_q == StIdle) ? cb_prefix : cb_q;
    dec_legal = 1'b1;
    dec_op    = cur_op[5:3];
    dec_ext   = 1'b0;
    dec_misc  = 1'b0;
    dec_src   = cur_op[2:0];
    dec_dest  = cur_op[2:0];
    dec_use_a = 1'b0;
    if (!cur_cb) begin
      dec_dest = IdxA;
      if (cur_op[7:6] == 2'b10) begin
        dec_use_a = 1'b1;
      end else if (cur_op[7:5] == 3'b001 && cur_op[2:0] == 3'b111) begin
        dec_op   = {1'b0, cur_op[4:3]};
        dec_misc = 1'b1;
        dec_src  = IdxA;
      end else begin
        dec_legal = 1'b0;
      end
    end else if (cur_op[7:6] != 2'b00) begin
      dec_op   = {1'b0, cur_op[7:6]};
      dec_ext  = 1'b1;
      dec_misc = 1'b1;
      dec_src  = cur_op[5:3];
    end else begin
      dec_ext = 1'b1;
    end
    dec_opnd = dec_use_a ? dec_src : dec_dest;
  end

  assign rd_active    = (state_q == StIdle && instr_valid) || state_q == StMemRd;
  assign rf_rd_addr_a = rd_active ? dec_opnd : 3'd0;
  assign rf_rd_addr_b = rd_active ? IdxA : 3'd0;
  assign opnd_data    = (dec_opnd == IdxHl) ? mem_rdata : rf_rd_data_a;

  // RES/SET leave flags alone; CP and BIT only produce flags.
  assign is_bitop   = alu_ext_q && alu_misc_q;
  assign no_flags   = is_bitop && alu_op_q[1];
  assign writes_res = !((!alu_ext_q && !alu_misc_q && alu_op_q == 3'd7) ||
                        (is_bitop && alu_op_q == 3'd1));

  always_comb begin
    state_d       = state_q;
    load_alu      = 1'b0;
    done_d        = 1'b0;
    instr_ready   = 1'b0;
    mem_rd_req    = 1'b0;
    mem_wr_req    = 1'b0;
    mem_wdata     = 8'd0;
    alu_begin     = 1'b0;
    rf_wr_en      = 1'b0;
    rf_wr_addr    = 3'd0;
    rf_wr_data    = 8'd0;
    flags_wr_en   = 1'b0;
    flags_wr_data = 8'd0;
    case (state_q)
      StIdle: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          if (!dec_legal) begin
            done_d = 1'b1;
          end else if (dec_opnd == IdxHl) begin
            state_d = StMemRd;
          end else begin
            state_d  = StExec;
            load_alu = 1'b1;
          end
        end
      end
      StMemRd: begin
        mem_rd_req = 1'b1;
        if (mem_ack) begin
          state_d  = StExec;
          load_alu = 1'b1;
        end
      end
      StExec: begin
        alu_begin = 1'b1;
        state_d   = StWait;
      end
      StWait: state_d = StWb;
      StWb: begin
        if (!no_flags) begin
          flags_wr_en   = 1'b1;
          flags_wr_data = alu_flags_res;
        end
        if (writes_res && alu_dest_addr_q != IdxHl) begin
          rf_wr_en   = 1'b1;
          rf_wr_addr = alu_dest_addr_q;
          rf_wr_data = alu_res;
        end
        if (writes_res && alu_dest_addr_q == IdxHl) begin
          state_d = StMemWr;
        end else begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StMemWr: begin
        mem_wr_req = 1'b1;
        mem_wdata  = res_q;
        if (mem_ack) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      op_q            <= 8'd0;
      cb_q            <= 1'b0;
      res_q           <= 8'd0;
      done_q          <= 1'b0;
      alu_op_q        <= 3'd0;
      alu_ext_q       <= 1'b0;
      alu_misc_q      <= 1'b0;
      alu_src_addr_q  <= 3'd0;
      alu_dest_addr_q <= 3'd0;
      alu_src_data_q  <= 8'd0;
      alu_dest_data_q <= 8'd0;
      alu_flags_in_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (state_q == StIdle && instr_valid) begin
        op_q <= opcode;
        cb_q <= cb_prefix;
      end
      if (state_q == StWb) res_q <= alu_res;
      if (load_alu) begin
        alu_op_q        <= dec_op;
        alu_ext_q       <= dec_ext;
        alu_misc_q      <= dec_misc;
        alu_src_addr_q  <= dec_src;
        alu_dest_addr_q <= dec_dest;
        alu_src_data_q  <= opnd_data;
        alu_dest_data_q <= dec_use_a ? rf_rd_data_b : opnd_data;
        alu_flags_in_q  <= flags_q;
      end
    end
  end

  assign alu_op        = alu_op_q;
  assign alu_ext       = alu_ext_q;
  assign alu_misc      = alu_misc_q;
  assign alu_src_addr  = alu_src_addr_q;
  assign alu_dest_addr = alu_dest_addr_q;
  assign alu_src_data  = alu_src_data_q;
  assign alu_dest_data = alu_dest_data_q;
  assign alu_flags_in  = alu_flags_in_q;
  assign done          = done_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Randomized self-checking bench for alu_dispatch; expectations come from an instruction-level
// model of the decode table, write-back rules and handshake latency.
module tb_alu_dispatch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       instr_valid, instr_ready, cb_prefix;
  logic [7:0] opcode;
  logic [2:0] rf_rd_addr_a, rf_rd_addr_b, rf_wr_addr;
  logic [7:0] rf_rd_data_a, rf_rd_data_b, rf_wr_data;
  logic       rf_wr_en, flags_wr_en, mem_rd_req, mem_wr_req, mem_ack;
  logic [7:0] flags_q, flags_wr_data, mem_wdata, mem_rdata;
  logic [2:0] alu_op, alu_src_addr, alu_dest_addr;
  logic       alu_ext, alu_misc, alu_begin, done;
  logic [7:0] alu_src_data, alu_dest_data, alu_flags_in, alu_res, alu_flags_res;

  logic [7:0] regs [8];
  logic [7:0] mem_val;
  int         n_checks = 0;
  int         n_errors = 0;

  always #5 clk = ~clk;

  assign rf_rd_data_a = regs[rf_rd_addr_a];
  assign rf_rd_data_b = regs[rf_rd_addr_b];

  alu_dispatch dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode(opcode), .cb_prefix(cb_prefix),
    .rf_rd_addr_a(rf_rd_addr_a), .rf_rd_data_a(rf_rd_data_a),
    .rf_rd_addr_b(rf_rd_addr_b), .rf_rd_data_b(rf_rd_data_b),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .flags_q(flags_q), .flags_wr_en(flags_wr_en), .flags_wr_data(flags_wr_data),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_op(alu_op), .alu_ext(alu_ext), .alu_misc(alu_misc),
    .alu_src_addr(alu_src_addr), .alu_dest_addr(alu_dest_addr),
    .alu_src_data(alu_src_data), .alu_dest_data(alu_dest_data),
    .alu_flags_in(alu_flags_in), .alu_begin(alu_begin),
    .alu_res(alu_res), .alu_flags_res(alu_flags_res), .done(done)
  );

  logic [34:0] alu_vec;
  logic        any_out;
  assign alu_vec = {alu_op, alu_ext, alu_misc, alu_src_addr, alu_dest_addr,
                    alu_src_data, alu_dest_data, alu_flags_in};
  assign any_out = |{rf_rd_addr_a, rf_rd_addr_b, rf_wr_en, rf_wr_addr, rf_wr_data, flags_wr_en,
                     flags_wr_data, mem_rd_req, mem_wr_req, mem_wdata, alu_vec, alu_begin, done};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one instruction at a negedge and watch it to completion; returns at a negedge.
  task automatic run_instr(input logic cb, input logic [7:0] op, input int rd_wait,
                           input int wr_wait);
    logic        base, misc, extk, bitk, legal, wr_res, wr_flags, to_mem, to_rf, use_mem;
    logic [2:0]  e_op, e_src, e_dst, o_idx;
    logic        e_ext, e_misc;
    logic [7:0]  opnd;
    logic [34:0] exp_snap, snap;
    logic [10:0] rf_seen;
    logic [7:0]  fl_seen, mem_seen;
    int          exp_lat, done_cyc, begins, rf_wrs, fl_wrs, rd_cyc, wr_cyc, mem_wrs, both;
    logic        stable;

    // Instruction-level model
    base  = !cb && op[7:6] == 2'b10;
    misc  = !cb && (op == 8'h27 || op == 8'h2F || op == 8'h37 || op == 8'h3F);
    extk  = cb && op[7:6] == 2'b00;
    bitk  = cb && op[7:6] != 2'b00;
    legal = base || misc || extk || bitk;
    e_op = op[5:3]; e_ext = extk || bitk; e_misc = misc || bitk;
    e_src = op[2:0]; e_dst = op[2:0];
    if (base) e_dst = 3'd7;
    if (misc) begin e_op = {1'b0, op[4:3]}; e_src = 3'd7; e_dst = 3'd7; end
    if (bitk) begin e_op = {1'b0, op[7:6]}; e_src = op[5:3]; end
    o_idx    = misc ? 3'd7 : op[2:0];
    opnd     = (o_idx == 3'd6) ? mem_val : regs[o_idx];
    exp_snap = {e_op, e_ext, e_misc, e_src, e_dst, opnd, base ? regs[7] : opnd, flags_q};
    wr_flags = legal && !(bitk && op[7]);
    wr_res   = legal && !(base && op[5:3] == 3'd7) && !(bitk && op[7:6] == 2'b01);
    to_mem   = wr_res && e_dst == 3'd6;
    to_rf    = wr_res && e_dst != 3'd6;
    use_mem  = legal && o_idx == 3'd6;
    exp_lat  = !legal ? 1 : 4 + (use_mem ? rd_wait + 1 : 0) + (to_mem ? wr_wait + 1 : 0);

    done_cyc = 0; begins = 0; rf_wrs = 0; fl_wrs = 0; rd_cyc = 0; wr_cyc = 0; mem_wrs = 0;
    both = 0; stable = 1'b1; snap = '0; rf_seen = '0; fl_seen = '0; mem_seen = '0;

    opcode = op; cb_prefix = cb; instr_valid = 1'b1; mem_ack = 1'b0;
    mem_rdata = 8'($urandom);
    #1;
    check("ready_idle", 64'(instr_ready), 64'(1));
    @(negedge clk);
    instr_valid = 1'b0; opcode = 8'($urandom); cb_prefix = 1'($urandom);
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (alu_begin) begin
        begins++;
        snap = alu_vec;
      end else if (begins > 0 && alu_vec !== snap) begin
        stable = 1'b0;
      end
      if (rf_wr_en) begin rf_wrs++; rf_seen = {rf_wr_addr, rf_wr_data}; end
      if (flags_wr_en) begin fl_wrs++; fl_seen = flags_wr_data; end
      if (mem_rd_req && mem_wr_req) both++;
      mem_ack = 1'b0;
      mem_rdata = 8'($urandom);
      if (mem_rd_req) begin
        rd_cyc++;
        if (rd_cyc == rd_wait + 1) begin mem_ack = 1'b1; mem_rdata = mem_val; end
      end else if (mem_wr_req) begin
        wr_cyc++;
        if (wr_cyc == wr_wait + 1) begin mem_ack = 1'b1; mem_wrs++; mem_seen = mem_wdata; end
      end else begin
        mem_ack = 1'($urandom);  // stray acks must be ignored
      end
      if (done) done_cyc = c;
      else @(negedge clk);
    end

    check("latency", 64'(done_cyc), 64'(exp_lat));
    check("alu_begin_count", 64'(begins), 64'(legal ? 1 : 0));
    if (legal) begin
      check("alu_fields", 64'(snap), 64'(exp_snap));
      check("alu_stable", 64'(stable), 64'(1));
    end
    check("mem_rd_cycles", 64'(rd_cyc), 64'(use_mem ? rd_wait + 1 : 0));
    check("rf_wr_count", 64'(rf_wrs), 64'(to_rf ? 1 : 0));
    if (to_rf) check("rf_wr", 64'(rf_seen), 64'({e_dst, alu_res}));
    check("flags_wr_count", 64'(fl_wrs), 64'(wr_flags ? 1 : 0));
    if (wr_flags) check("flags_wr", 64'(fl_seen), 64'(alu_flags_res));
    check("mem_wr_count", 64'(mem_wrs), 64'(to_mem ? 1 : 0));
    if (to_mem) check("mem_wdata", 64'(mem_seen), 64'(alu_res));
    check("rd_wr_overlap", 64'(both), 64'(0));

    @(negedge clk);
    mem_ack = 1'b0;
    check("done_pulse", 64'(done), 64'(0));
    check("ready_after", 64'(instr_ready), 64'(1));
  endtask

  task automatic reset_mid_op();
    int bad = 0;
    for (int r = 0; r < 8; r++) regs[r] = 8'($urandom);
    opcode = 8'h80; cb_prefix = 1'b0; instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    if (rf_wr_en || flags_wr_en || mem_wr_req || done) bad++;
    @(negedge clk);  // instruction now in WAIT
    if (rf_wr_en || flags_wr_en || mem_wr_req || done) bad++;
    rst_n = 1'b0;
    #1;
    check("midrst_ready", 64'(instr_ready), 64'(1));
    check("midrst_outs", 64'(any_out), 64'(0));
    repeat (2) begin
      @(negedge clk);
      if (rf_wr_en || flags_wr_en || mem_wr_req || done) bad++;
      if (!instr_ready) bad++;
    end
    check("midrst_quiet", 64'(bad), 64'(0));
    rst_n = 1'b1;
    // First cycle after release must accept.
    mem_val = 8'($urandom);
    run_instr(1'b0, 8'hA1, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       cb;
    logic [7:0] op;
    int         sel;
    rst_n = 1'b0; instr_valid = 1'b0; opcode = 8'h00; cb_prefix = 1'b0; mem_ack = 1'b0;
    mem_rdata = 8'h00; flags_q = 8'h00; alu_res = 8'h00; alu_flags_res = 8'h00; mem_val = 8'h00;
    for (int r = 0; r < 8; r++) regs[r] = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_ready", 64'(instr_ready), 64'(1));
    check("rst_outs", 64'(any_out), 64'(0));
    rst_n = 1'b1;

    // ADD A,B
    regs[7] = 8'h3C; regs[0] = 8'h0F; alu_res = 8'h4B; alu_flags_res = 8'h20; flags_q = 8'h10;
    run_instr(1'b0, 8'h80, 0, 0);
    // CP B
    alu_res = 8'h55; alu_flags_res = 8'hC0;
    run_instr(1'b0, 8'hB8, 0, 0);
    // BIT 0,(HL) with a slow read
    mem_val = 8'h01; alu_flags_res = 8'hA0;
    run_instr(1'b1, 8'h46, 3, 0);
    // SET 0,(HL)
    mem_val = 8'h80; alu_res = 8'h81;
    run_instr(1'b1, 8'hC6, 0, 2);
    // Illegal NOP
    run_instr(1'b0, 8'h00, 0, 0);

    reset_mid_op();

    for (int i = 0; i < 150; i++) begin
      for (int r = 0; r < 8; r++) regs[r] = 8'($urandom);
      mem_val = 8'($urandom); alu_res = 8'($urandom);
      alu_flags_res = 8'($urandom); flags_q = 8'($urandom);
      sel = int'($urandom_range(0, 9));
      if (sel < 4) begin
        cb = 1'b0; op = {2'b10, 6'($urandom)};
      end else if (sel == 4) begin
        cb = 1'b0; op = {3'b001, 2'($urandom), 3'b111};
      end else if (sel < 9) begin
        cb = 1'b1; op = 8'($urandom);
      end else begin
        cb = 1'b0; op = 8'($urandom);
      end
      run_instr(cb, op, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
